// File: rtl/blackjack_round_judge.sv
// Round judge: latches each player's hand total as they finish, scans for the winner(s),
// converts the winning score to BCD and keeps saturating per-player win tallies.
module blackjack_round_judge #(
    parameter int NUM_PLAYERS = 2,
    parameter int VALUE_W     = 5,
    parameter int TARGET      = 21,
    parameter int QUAL_MIN    = 20,
    parameter int WIN_CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             round_start,
    input  logic [NUM_PLAYERS-1:0]           finish,
    input  logic [NUM_PLAYERS*VALUE_W-1:0]   total_values,
    input  logic                             result_ack,
    input  logic                             tally_clear,
    output logic                             busy,
    output logic                             result_valid,
    output logic [NUM_PLAYERS-1:0]           winner_mask,
    output logic [7:0]                       score_bcd,
    output logic [NUM_PLAYERS*WIN_CNT_W-1:0] win_tally
);

    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CNT_W = $clog2(NUM_PLAYERS + 1);
    localparam logic [VALUE_W-1:0] TARGET_V = VALUE_W'(TARGET);
    localparam logic [VALUE_W-1:0] QUAL_V   = VALUE_W'(QUAL_MIN);
    localparam logic [VALUE_W-1:0] TEN_V    = VALUE_W'(10);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SCAN,
        RESOLVE,
        CONV,
        DONE
    } judgeState;

    judgeState              state;
    logic [VALUE_W-1:0]     handTotal [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] finishedQ;
    logic [IDX_W-1:0]       scanIdx;
    logic [IDX_W-1:0]       aliveIdx;
    logic [CNT_W-1:0]       aliveCnt;
    logic [VALUE_W-1:0]     best;
    logic [VALUE_W-1:0]     remVal;
    logic [3:0]             tensDigit;

    logic                   allFinished;
    logic [VALUE_W-1:0]     scanVal;
    logic [NUM_PLAYERS-1:0] resolveMask;
    logic [VALUE_W-1:0]     resolveVal;

    assign allFinished = &(finishedQ | finish);
    assign scanVal     = handTotal[scanIdx];

    // A lone survivor wins even below QUAL_MIN; otherwise all hands equal to best share the win.
    always_comb begin
        resolveMask = '0;
        resolveVal  = '0;
        if (aliveCnt == CNT_W'(1)) begin
            resolveMask[aliveIdx] = 1'b1;
            resolveVal            = handTotal[aliveIdx];
        end else if (aliveCnt >= CNT_W'(2) && best != '0) begin
            resolveVal = best;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (handTotal[i] == best) begin
                    resolveMask[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner_mask  <= '0;
            score_bcd    <= '0;
            win_tally    <= '0;
            finishedQ    <= '0;
            scanIdx      <= '0;
            aliveIdx     <= '0;
            aliveCnt     <= '0;
            best         <= '0;
            remVal       <= '0;
            tensDigit    <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                handTotal[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (round_start) begin
                        state       <= COLLECT;
                        busy        <= 1'b1;
                        finishedQ   <= '0;
                        winner_mask <= '0;
                        score_bcd   <= '0;
                        scanIdx     <= '0;
                        aliveIdx    <= '0;
                        aliveCnt    <= '0;
                        best        <= '0;
                    end
                end
                COLLECT: begin
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        if (finish[i] && !finishedQ[i]) begin
                            handTotal[i] <= total_values[i*VALUE_W +: VALUE_W];
                            finishedQ[i] <= 1'b1;
                        end
                    end
                    if (allFinished) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (scanVal <= TARGET_V) begin
                        aliveCnt <= aliveCnt + CNT_W'(1);
                        aliveIdx <= scanIdx;
                        if (scanVal >= QUAL_V && scanVal > best) begin
                            best <= scanVal;
                        end
                    end
                    if (scanIdx == LAST_IDX) begin
                        state <= RESOLVE;
                    end else begin
                        scanIdx <= scanIdx + IDX_W'(1);
                    end
                end
                RESOLVE: begin
                    winner_mask <= resolveMask;
                    remVal      <= resolveVal;
                    tensDigit   <= '0;
                    state       <= CONV;
                end
                CONV: begin
                    if (remVal >= TEN_V) begin
                        remVal    <= remVal - TEN_V;
                        tensDigit <= tensDigit + 4'd1;
                    end else begin
                        score_bcd    <= {tensDigit, remVal[3:0]};
                        result_valid <= 1'b1;
                        state        <= DONE;
                        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                            if (winner_mask[i] && win_tally[i*WIN_CNT_W +: WIN_CNT_W] != '1) begin
                                win_tally[i*WIN_CNT_W +: WIN_CNT_W] <=
                                    win_tally[i*WIN_CNT_W +: WIN_CNT_W] + WIN_CNT_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a same-edge increment.
            if (tally_clear) begin
                win_tally <= '0;
            end
        end
    end

endmodule

// File: tb/tb_blackjack_round_judge.sv
// Bench for blackjack_round_judge: a 2-player and a 4-player instance driven by
// scenario tasks and checked against a rule-level model of each round.
module tb_blackjack_round_judge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rs2, rs4, ack2, ack4, clr2, clr4;
    logic [1:0]  fin2;
    logic [3:0]  fin4;
    logic [9:0]  tv2;
    logic [19:0] tv4;
    logic        busy2, valid2, busy4, valid4;
    logic [1:0]  mask2;
    logic [3:0]  mask4;
    logic [7:0]  bcd2, bcd4;
    logic [15:0] tally2;
    logic [31:0] tally4;

    int total = 0;
    int bad = 0;
    int mTally[2][4];

    blackjack_round_judge #(.NUM_PLAYERS(2), .VALUE_W(5), .TARGET(21), .QUAL_MIN(20), .WIN_CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .round_start(rs2), .finish(fin2), .total_values(tv2),
        .result_ack(ack2), .tally_clear(clr2), .busy(busy2), .result_valid(valid2),
        .winner_mask(mask2), .score_bcd(bcd2), .win_tally(tally2)
    );

    blackjack_round_judge #(.NUM_PLAYERS(4), .VALUE_W(5), .TARGET(21), .QUAL_MIN(20), .WIN_CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .round_start(rs4), .finish(fin4), .total_values(tv4),
        .result_ack(ack4), .tally_clear(clr4), .busy(busy4), .result_valid(valid4),
        .winner_mask(mask4), .score_bcd(bcd4), .win_tally(tally4)
    );

    function automatic logic getValid(input bit f);
        return f ? valid4 : valid2;
    endfunction
    function automatic logic getBusy(input bit f);
        return f ? busy4 : busy2;
    endfunction
    function automatic logic [3:0] getMask(input bit f);
        return f ? mask4 : {2'b00, mask2};
    endfunction
    function automatic logic [7:0] getBcd(input bit f);
        return f ? bcd4 : bcd2;
    endfunction
    function automatic logic [7:0] getTally(input bit f, input int i);
        if (f) return tally4[i*8 +: 8];
        return tally2[i*8 +: 8];
    endfunction

    task automatic setStart(input bit f, input logic v);
        if (f) rs4 = v; else rs2 = v;
    endtask
    task automatic setAck(input bit f, input logic v);
        if (f) ack4 = v; else ack2 = v;
    endtask
    task automatic setClr(input bit f, input logic v);
        if (f) clr4 = v; else clr2 = v;
    endtask
    task automatic setFinish(input bit f, input int i, input logic v);
        if (f) fin4[i] = v; else fin2[i] = v;
    endtask
    task automatic setTotal(input bit f, input int i, input int v);
        if (f) tv4[i*5 +: 5] = 5'(v); else tv2[i*5 +: 5] = 5'(v);
    endtask

    // One full round: fa[i] = COLLECT cycle (1-based) at which player i raises finish.
    task automatic runRound(input bit f, input int tv[4], input int fa[4], input int ackDelay,
                            input bit poke, input bit clrHit, input string tag);
        int n, alive, aliveI, best, win, expLat, lastK, cnt;
        logic [3:0] expMask;
        logic [7:0] expBcd;
        n = f ? 4 : 2;
        alive = 0; aliveI = 0; best = 0; win = 0; expMask = '0; lastK = 1;
        for (int i = 0; i < n; i++) begin
            if (tv[i] <= 21) begin
                alive++;
                aliveI = i;
                if (tv[i] >= 20 && tv[i] > best) best = tv[i];
            end
            if (fa[i] > lastK) lastK = fa[i];
        end
        if (alive == 1) begin
            expMask[aliveI] = 1'b1;
            win = tv[aliveI];
        end else if (alive >= 2 && best != 0) begin
            win = best;
            for (int i = 0; i < n; i++) if (tv[i] == best) expMask[i] = 1'b1;
        end
        expBcd = 8'((win / 10) * 16 + (win % 10));
        expLat = n + win / 10 + 2;

        for (int i = 0; i < n; i++) begin
            setTotal(f, i, tv[i]);
            setFinish(f, i, 1'b0);
        end
        setStart(f, 1'b1);
        @(posedge clk); #1;
        setStart(f, 1'b0);
        total++;
        if (getBusy(f) !== 1'b1) begin
            bad++;
            $display("FAIL %s/busy_rise got=%b want=1", tag, getBusy(f));
        end
        for (int c = 1; c <= lastK; c++) begin
            for (int i = 0; i < n; i++) begin
                if (fa[i] == c) begin
                    setFinish(f, i, 1'b1);
                end else if (fa[i] < c) begin
                    setTotal(f, i, int'($urandom_range(0, 31)));
                    setFinish(f, i, 1'($urandom_range(0, 1)));
                end
            end
            @(posedge clk); #1;
        end

        cnt = 0;
        while (getValid(f) !== 1'b1 && cnt < 64) begin
            if (clrHit && cnt == expLat - 1) setClr(f, 1'b1);
            @(posedge clk); #1;
            setClr(f, 1'b0);
            cnt++;
        end
        total++;
        if (cnt != expLat) begin
            bad++;
            $display("FAIL %s/latency got=%0d want=%0d", tag, cnt, expLat);
        end

        for (int i = 0; i < n; i++) begin
            if (clrHit) mTally[f][i] = 0;
            else if (expMask[i] && mTally[f][i] < 255) mTally[f][i]++;
        end
        total++;
        if (getMask(f) !== expMask) begin
            bad++;
            $display("FAIL %s/mask got=%b want=%b", tag, getMask(f), expMask);
        end
        total++;
        if (getBcd(f) !== expBcd) begin
            bad++;
            $display("FAIL %s/bcd got=%h want=%h", tag, getBcd(f), expBcd);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (getTally(f, i) !== 8'(mTally[f][i])) begin
                bad++;
                $display("FAIL %s/tally%0d got=%0d want=%0d", tag, i, getTally(f, i), mTally[f][i]);
            end
        end

        for (int d = 0; d < ackDelay; d++) begin
            if (poke && d == 2) setStart(f, 1'b1);
            @(posedge clk); #1;
            setStart(f, 1'b0);
            total++;
            if (getValid(f) !== 1'b1 || getMask(f) !== expMask || getBcd(f) !== expBcd) begin
                bad++;
                $display("FAIL %s/hold valid=%b mask=%b bcd=%h want 1/%b/%h",
                         tag, getValid(f), getMask(f), getBcd(f), expMask, expBcd);
            end
        end

        setAck(f, 1'b1);
        @(posedge clk); #1;
        setAck(f, 1'b0);
        total++;
        if (getValid(f) !== 1'b0 || getBusy(f) !== 1'b0) begin
            bad++;
            $display("FAIL %s/ack valid=%b busy=%b want 0/0", tag, getValid(f), getBusy(f));
        end
        @(posedge clk); #1;
        total++;
        if (getBusy(f) !== 1'b0 || getMask(f) !== expMask || getBcd(f) !== expBcd) begin
            bad++;
            $display("FAIL %s/idle_hold busy=%b mask=%b bcd=%h want 0/%b/%h",
                     tag, getBusy(f), getMask(f), getBcd(f), expMask, expBcd);
        end
    endtask

    task automatic checkAllZero(input string tag);
        total++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0 || mask2 !== 2'b00 || bcd2 !== 8'h00 || tally2 !== 16'h0) begin
            bad++;
            $display("FAIL %s/dut2 busy=%b valid=%b mask=%b bcd=%h tally=%h want all 0",
                     tag, busy2, valid2, mask2, bcd2, tally2);
        end
        total++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0 || mask4 !== 4'b0 || bcd4 !== 8'h00 || tally4 !== 32'h0) begin
            bad++;
            $display("FAIL %s/dut4 busy=%b valid=%b mask=%b bcd=%h tally=%h want all 0",
                     tag, busy4, valid4, mask4, bcd4, tally4);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int f = 0; f < 2; f++) for (int i = 0; i < 4; i++) mTally[f][i] = 0;
        checkAllZero("reset");
    endtask

    task automatic test_win_higher;
        runRound(1'b0, '{20, 21, 0, 0}, '{1, 1, 1, 1}, 0, 1'b0, 1'b0, "win_higher");
    endtask

    task automatic test_sole_survivor;
        runRound(1'b0, '{23, 15, 0, 0}, '{2, 1, 1, 1}, 1, 1'b0, 1'b0, "sole");
        runRound(1'b0, '{22, 25, 0, 0}, '{1, 3, 1, 1}, 0, 1'b0, 1'b0, "all_bust");
    endtask

    task automatic test_no_qualifier;
        runRound(1'b1, '{18, 19, 17, 5}, '{1, 1, 1, 1}, 0, 1'b0, 1'b0, "no_qual");
        runRound(1'b1, '{20, 21, 21, 30}, '{2, 1, 4, 3}, 2, 1'b0, 1'b0, "tie4");
    endtask

    task automatic test_handshake;
        runRound(1'b0, '{20, 21, 0, 0}, '{3, 9, 1, 1}, 10, 1'b1, 1'b0, "handshake");
    endtask

    task automatic test_random;
        int tv[4];
        int fa[4];
        bit f;
        for (int r = 0; r < 30; r++) begin
            f = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                tv[i] = int'($urandom_range(10, 31));
                fa[i] = int'($urandom_range(1, 5));
            end
            runRound(f, tv, fa, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    task automatic test_tally_clear;
        runRound(1'b1, '{20, 21, 21, 30}, '{1, 2, 1, 3}, 1, 1'b0, 1'b1, "clr_hit");
    endtask

    task automatic test_reset_mid_scan;
        setTotal(1'b0, 0, 21);
        setTotal(1'b0, 1, 20);
        fin2 = 2'b11;
        rs2 = 1'b1;
        @(posedge clk); #1;
        rs2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fin2 = 2'b00;
        for (int f = 0; f < 2; f++) for (int i = 0; i < 4; i++) mTally[f][i] = 0;
        checkAllZero("rst_scan");
        runRound(1'b0, '{21, 20, 0, 0}, '{1, 2, 1, 1}, 0, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_tie_saturate;
        for (int r = 0; r < 300; r++) begin
            runRound(1'b0, '{21, 21, 0, 0}, '{1, 1, 1, 1}, 0, 1'b0, 1'b0, "tie_sat");
        end
        total++;
        if (tally2 !== 16'hFFFF) begin
            bad++;
            $display("FAIL tie_sat/final got=%h want=ffff", tally2);
        end
    endtask

    initial begin
        rst = 1'b1;
        rs2 = 1'b0; rs4 = 1'b0; ack2 = 1'b0; ack4 = 1'b0; clr2 = 1'b0; clr4 = 1'b0;
        fin2 = '0; fin4 = '0; tv2 = '0; tv4 = '0;
        test_reset;
        test_win_higher;
        test_sole_survivor;
        test_no_qualifier;
        test_handshake;
        test_random;
        test_tally_clear;
        test_reset_mid_scan;
        test_tie_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
